// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the data memory.
// Latches one request, issues it for a cycle, waits out read latency, then acks.
module dm_port_arbiter #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_uns,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wd,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_uns,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wd,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [3:0]  dm_bes,
  output logic [6:0]  dm_bel,
  input  logic [31:0] dm_rdata,
  output logic        busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d, id_q, id_d, we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wd_q, wd_d;

  logic        gnt, g_we, g_uns;
  logic [1:0]  g_size;
  logic [31:0] g_addr, g_wd, rd_out;
  logic [3:0]  lanes;
  logic [2:0]  ld_code;

  function automatic logic illegal(input logic [1:0] size, input logic [1:0] a);
    return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a != 2'b00);
  endfunction

  // On a tie the port that did not win last time gets the grant.
  assign gnt    = p1_req & (~p0_req | ~last_q);
  assign g_we   = gnt ? p1_we   : p0_we;
  assign g_size = gnt ? p1_size : p0_size;
  assign g_uns  = gnt ? p1_uns  : p0_uns;
  assign g_addr = gnt ? p1_addr : p0_addr;
  assign g_wd   = gnt ? p1_wd   : p0_wd;

  always_comb begin
    lanes   = 4'b0001 << addr_q[1:0];
    ld_code = 3'b000;
    unique case (size_q)
      2'b10:   lanes = 4'b1111;
      2'b01: begin
        lanes   = addr_q[1] ? 4'b1100 : 4'b0011;
        ld_code = uns_q ? 3'b010 : 3'b001;
      end
      default: ld_code = uns_q ? 3'b100 : 3'b011;
    endcase
  end

  assign rd_out  = (!err_q && !we_q) ? dm_rdata : '0;
  assign dm_addr = addr_q;
  assign dm_wd   = wd_q;
  assign busy    = (state_q != S_IDLE);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    we_d     = we_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wd_d     = wd_q;
    err_d    = err_q;
    dm_we    = 1'b0;
    dm_bes   = 4'b0000;
    dm_bel   = 7'b0;
    p0_ack   = 1'b0;
    p0_err   = 1'b0;
    p0_rdata = '0;
    p1_ack   = 1'b0;
    p1_err   = 1'b0;
    p1_rdata = '0;
    unique case (state_q)
      S_IDLE: if (p0_req || p1_req) begin
        last_d  = gnt;
        id_d    = gnt;
        we_d    = g_we;
        size_d  = g_size;
        uns_d   = g_uns;
        addr_d  = g_addr;
        wd_d    = g_wd;
        err_d   = illegal(g_size, g_addr[1:0]);
        state_d = err_d ? S_ACK : S_ISSUE;
      end
      S_ISSUE: begin
        if (we_q) begin
          dm_we   = 1'b1;
          dm_bes  = lanes;
          state_d = S_ACK;
        end else begin
          dm_bel  = {ld_code, lanes};
          state_d = (LAT == 1) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        dm_bel  = {ld_code, lanes};
        state_d = S_ACK;
      end
      S_ACK: begin
        p0_ack   = ~id_q;
        p0_err   = ~id_q & err_q;
        p0_rdata = id_q ? '0 : rd_out;
        p1_ack   = id_q;
        p1_err   = id_q & err_q;
        p1_rdata = id_q ? rd_out : '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench: LAT=1 instance with a byte-lane memory model, LAT=2 instance for abort.
module tb_dm_port_arbiter;
  logic clk = 1'b0;
  logic rst_a, rst_b, sel;
  logic p0_req, p0_we, p0_uns, p1_req, p1_we, p1_uns;
  logic [1:0]  p0_size, p1_size;
  logic [31:0] p0_addr, p0_wd, p1_addr, p1_wd;

  logic        a_p0_ack, a_p0_err, a_p1_ack, a_p1_err, a_dm_we, a_busy;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_dm_addr, a_dm_wd, a_dm_rdata;
  logic [3:0]  a_dm_bes;
  logic [6:0]  a_dm_bel;
  logic        b_p0_ack, b_p0_err, b_p1_ack, b_p1_err, b_dm_we, b_busy;
  logic [31:0] b_p0_rdata, b_p1_rdata, b_dm_addr, b_dm_wd, b_dm_rdata;
  logic [3:0]  b_dm_bes;
  logic [6:0]  b_dm_bel;

  logic        o_p0_ack, o_p0_err, o_p1_ack, o_p1_err, o_dm_we, o_busy;
  logic [31:0] o_p0_rdata, o_p1_rdata, o_dm_addr, o_dm_wd;
  logic [3:0]  o_dm_bes;
  logic [6:0]  o_dm_bel;

  int n_tests = 0, n_fail = 0;
  logic [3:0]  is_bes;
  logic [6:0]  is_bel;
  logic [31:0] is_addr, is_wd;
  logic        we_seen;

  always #5 clk = ~clk;

  dm_port_arbiter #(.LAT(1)) u_a (
    .clk(clk), .rst(rst_a),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns), .p0_addr(p0_addr),
    .p0_wd(p0_wd), .p0_ack(a_p0_ack), .p0_err(a_p0_err), .p0_rdata(a_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns), .p1_addr(p1_addr),
    .p1_wd(p1_wd), .p1_ack(a_p1_ack), .p1_err(a_p1_err), .p1_rdata(a_p1_rdata),
    .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wd(a_dm_wd), .dm_bes(a_dm_bes),
    .dm_bel(a_dm_bel), .dm_rdata(a_dm_rdata), .busy(a_busy));

  dm_port_arbiter #(.LAT(2)) u_b (
    .clk(clk), .rst(rst_b),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns), .p0_addr(p0_addr),
    .p0_wd(p0_wd), .p0_ack(b_p0_ack), .p0_err(b_p0_err), .p0_rdata(b_p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns), .p1_addr(p1_addr),
    .p1_wd(p1_wd), .p1_ack(b_p1_ack), .p1_err(b_p1_err), .p1_rdata(b_p1_rdata),
    .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wd(b_dm_wd), .dm_bes(b_dm_bes),
    .dm_bel(b_dm_bel), .dm_rdata(b_dm_rdata), .busy(b_busy));

  assign o_p0_ack   = sel ? b_p0_ack   : a_p0_ack;
  assign o_p0_err   = sel ? b_p0_err   : a_p0_err;
  assign o_p0_rdata = sel ? b_p0_rdata : a_p0_rdata;
  assign o_p1_ack   = sel ? b_p1_ack   : a_p1_ack;
  assign o_p1_err   = sel ? b_p1_err   : a_p1_err;
  assign o_p1_rdata = sel ? b_p1_rdata : a_p1_rdata;
  assign o_dm_we    = sel ? b_dm_we    : a_dm_we;
  assign o_dm_addr  = sel ? b_dm_addr  : a_dm_addr;
  assign o_dm_wd    = sel ? b_dm_wd    : a_dm_wd;
  assign o_dm_bes   = sel ? b_dm_bes   : a_dm_bes;
  assign o_dm_bel   = sel ? b_dm_bel   : a_dm_bel;
  assign o_busy     = sel ? b_busy     : a_busy;

  // Memory for the LAT=1 instance: lane-masked writes, registered extending read.
  logic [31:0] mem [0:63];
  logic [31:0] a_ws, a_rd, b_r1, b_r2;
  assign a_ws       = a_dm_wd << {a_dm_addr[1:0], 3'b000};
  assign a_dm_rdata = a_rd;
  assign b_dm_rdata = b_r2;

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                      input logic [2:0] code);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    case (code)
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd2:    return {16'h0, s[15:0]};
      3'd3:    return {{24{s[7]}}, s[7:0]};
      3'd4:    return {24'h0, s[7:0]};
      default: return w;
    endcase
  endfunction

  always @(posedge clk) begin
    if (a_dm_we)
      for (int i = 0; i < 4; i++)
        if (a_dm_bes[i]) mem[a_dm_addr[7:2]][8*i +: 8] <= a_ws[8*i +: 8];
    a_rd <= ext(mem[a_dm_addr[7:2]], a_dm_addr[1:0], a_dm_bel[6:4]);
    b_r1 <= {16'hCAFE, b_dm_addr[15:0]};
    b_r2 <= b_r1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE to ack; leaves the DUT back in IDLE.
  task automatic xact(input string tag, input bit port, input logic we, input logic [1:0] size,
                      input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                      input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
    int n = 0;
    bit done = 0, stray = 0;
    logic got_err = 1'b0;
    logic [31:0] got_rd = '0;
    if (port) begin
      p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wd = wd; p1_req = 1'b1;
    end else begin
      p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wd = wd; p0_req = 1'b1;
    end
    we_seen = 1'b0;
    while (!done && n < 12) begin
      tick();
      n++;
      if (n == 1) begin
        is_bes = o_dm_bes; is_bel = o_dm_bel; is_addr = o_dm_addr; is_wd = o_dm_wd;
      end
      we_seen |= o_dm_we;
      if (port ? o_p0_ack : o_p1_ack) stray = 1;
      if (port ? o_p1_ack : o_p0_ack) begin
        done    = 1;
        got_err = port ? o_p1_err : o_p0_err;
        got_rd  = port ? o_p1_rdata : o_p0_rdata;
      end
    end
    chk({tag, " lat"}, n, exp_lat);
    chk({tag, " err"}, 32'(got_err), 32'(exp_err));
    chk({tag, " rdata"}, got_rd, exp_rd);
    chk({tag, " stray ack"}, 32'(stray), 32'd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  initial begin
    int k, both;
    logic [31:0] ord [6];
    logic [31:0] rds [6];
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    p0_req = 0; p0_we = 0; p0_size = 0; p0_uns = 0; p0_addr = 0; p0_wd = 0;
    p1_req = 0; p1_we = 0; p1_size = 0; p1_uns = 0; p1_addr = 0; p1_wd = 0;
    tick(); tick();
    chk("rst acks", {30'd0, o_p1_ack, o_p0_ack}, 32'd0);
    chk("rst errs", {30'd0, o_p1_err, o_p0_err}, 32'd0);
    chk("rst rdata", o_p0_rdata | o_p1_rdata, 32'd0);
    chk("rst dm", {21'd0, o_dm_we, o_dm_bes, o_dm_bel}, 32'd0);
    chk("rst addr", o_dm_addr | o_dm_wd, 32'd0);
    chk("rst busy", 32'(o_busy), 32'd0);

    // Tie right after reset: p0 first, p1 three cycles later.
    rst_a = 1'b0;
    p0_we = 1; p0_size = 2'b10; p0_addr = 32'h10; p0_wd = 32'hDEADBEEF; p0_req = 1;
    p1_we = 1; p1_size = 2'b10; p1_addr = 32'h14; p1_wd = 32'h12345678; p1_req = 1;
    tick();
    chk("tie issue we/bes", {27'd0, o_dm_we, o_dm_bes}, {27'd0, 1'b1, 4'b1111});
    chk("tie issue addr", o_dm_addr, 32'h10);
    tick();
    chk("tie p0 ack", {30'd0, o_p1_ack, o_p0_ack}, 32'd1);
    p0_req = 0;
    tick(); tick();
    chk("tie p1 addr", o_dm_addr, 32'h14);
    chk("tie p1 no ack yet", 32'(o_p1_ack), 32'd0);
    tick();
    chk("tie p1 ack", {30'd0, o_p1_ack, o_p0_ack}, 32'd2);
    p1_req = 0;
    tick();
    xact("lw 0x14", 0, 0, 2'b10, 0, 32'h14, 0, 2, 0, 32'h12345678);

    // Round robin with both held.
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    p0_we = 0; p0_size = 2'b10; p0_addr = 32'h10; p0_req = 1;
    p1_we = 0; p1_size = 2'b10; p1_addr = 32'h14; p1_req = 1;
    k = 0; both = 0;
    for (int t = 0; t < 60 && k < 6; t++) begin
      tick();
      if (o_p0_ack && o_p1_ack) both = 1;
      if (o_p0_ack || o_p1_ack) begin
        ord[k] = {31'd0, o_p1_ack};
        rds[k] = o_p1_ack ? o_p1_rdata : o_p0_rdata;
        k++;
      end
    end
    p0_req = 0; p1_req = 0;
    tick();
    chk("rr count", k, 6);
    chk("rr double ack", both, 0);
    for (int i = 0; i < k; i++) begin
      chk($sformatf("rr gnt %0d", i), ord[i], i % 2);
      chk($sformatf("rr rd %0d", i), rds[i], (i % 2) ? 32'h12345678 : 32'hDEADBEEF);
    end

    // Sub-word loads.
    xact("sw 0x20", 0, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 2, 0, 0);
    xact("lb 0x23", 0, 0, 2'b00, 0, 32'h23, 0, 2, 0, 32'hFFFFFF80);
    chk("lb bel", 32'(is_bel), 32'b0111000);
    xact("lbu 0x21", 1, 0, 2'b00, 1, 32'h21, 0, 2, 0, 32'h0000007F);
    chk("lbu bel", 32'(is_bel), 32'b1000010);
    xact("lh 0x22", 0, 0, 2'b01, 0, 32'h22, 0, 2, 0, 32'hFFFF80FF);
    chk("lh bel", 32'(is_bel), 32'b0011100);
    xact("lhu 0x20", 1, 0, 2'b01, 1, 32'h20, 0, 2, 0, 32'h00007F01);
    chk("lhu bel", 32'(is_bel), 32'b0100011);

    // Sub-word stores.
    xact("sw 0x30", 0, 1, 2'b10, 0, 32'h30, 32'h0, 2, 0, 0);
    xact("sb 0x31", 1, 1, 2'b00, 0, 32'h31, 32'h123456AA, 2, 0, 0);
    chk("sb bes", 32'(is_bes), 32'b0010);
    chk("sb wd unshifted", is_wd, 32'h123456AA);
    xact("sh 0x32", 0, 1, 2'b01, 0, 32'h32, 32'h00005555, 2, 0, 0);
    chk("sh bes", 32'(is_bes), 32'b1100);
    xact("lw 0x30", 1, 0, 2'b10, 0, 32'h30, 0, 2, 0, 32'h5555AA00);
    chk("lw bel", 32'(is_bel), 32'b0001111);

    // Illegal accesses never reach memory.
    xact("sw 0x40", 0, 1, 2'b10, 0, 32'h40, 32'h11223344, 2, 0, 0);
    xact("lw 0x42", 0, 0, 2'b10, 0, 32'h42, 0, 1, 1, 0);
    chk("lw 0x42 we", 32'(we_seen), 32'd0);
    xact("sh 0x41", 1, 1, 2'b01, 0, 32'h41, 32'hFFFF, 1, 1, 0);
    chk("sh 0x41 we", 32'(we_seen), 32'd0);
    xact("size11", 0, 1, 2'b11, 0, 32'h40, 32'hFFFFFFFF, 1, 1, 0);
    chk("size11 we", 32'(we_seen), 32'd0);
    xact("lw 0x40", 1, 0, 2'b10, 0, 32'h40, 0, 2, 0, 32'h11223344);

    // LAT=2 instance: reset during WAIT aborts the load.
    rst_a = 1'b1; sel = 1'b1; rst_b = 1'b0;
    p0_we = 0; p0_size = 2'b10; p0_uns = 0; p0_addr = 32'h40; p0_req = 1;
    tick(); tick();
    chk("wait busy", 32'(o_busy), 32'd1);
    chk("wait bel", 32'(o_dm_bel), 32'b0001111);
    chk("wait no ack", 32'(o_p0_ack), 32'd0);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0; p0_req = 0;
    chk("abort ack", {30'd0, o_p1_ack, o_p0_ack}, 32'd0);
    chk("abort busy", 32'(o_busy), 32'd0);
    chk("abort dm", {21'd0, o_dm_we, o_dm_bes, o_dm_bel}, 32'd0);
    chk("abort addr", o_dm_addr, 32'd0);
    xact("p1 lw lat2", 1, 0, 2'b10, 0, 32'h44, 0, 3, 0, 32'hCAFE0044);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
